// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle datapath control: FSM states, ALU op codes,
// mux selects and base-ISA opcodes.
// Pure declarations, no logic; also consumed by the ALU control decoder.
package riscv_pkg;

    // Debug-visible state encoding (4 bits on the state port)
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_EXEC_I   = 4'd7,
        ST_ALU_WB   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_FAULT    = 4'd11
    } state_e;

    // ALU operation requests to the ALU control decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALU_OUT  = 2'b00;
    localparam logic [1:0] RES_MEM_DATA = 2'b01;
    localparam logic [1:0] RES_ALU_RES  = 2'b10;

    // Memory address select
    localparam logic ADR_PC      = 1'b0;
    localparam logic ADR_ALU_OUT = 1'b1;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // States that wait on the memory handshake and are guarded by the timeout
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter used to bound how long the FSM stalls on memory.
// done is a combinational compare of the current count against LIMIT.
// clear has priority over tick; the count never wraps.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic done
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins, otherwise count stalled cycles and stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (tick && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register, asynchronously cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LIMIT[7:0]);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath: one state per datapath step.
// Strobes and selects are decoded from the current state (same-cycle on mem_ready/zero).
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; a stall longer than MEM_TIMEOUT faults.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       old_pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       fault,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;
    logic   fault_q;
    logic   tmr_clear;
    logic   tmr_tick;
    logic   tmr_done;

    // Next-state selection; mem_ready is only consulted in the wait states
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready)     state_d = ST_DECODE;
                else if (tmr_done) state_d = ST_FAULT;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
                    OP_RTYPE:          state_d = ST_EXEC_R;
                    OP_ITYPE:          state_d = ST_EXEC_I;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_JAL:            state_d = ST_JAL;
                    default:           state_d = ST_FAULT;
                endcase
            end
            ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready)     state_d = ST_MEM_WB;
                else if (tmr_done) state_d = ST_FAULT;
            end
            ST_MEM_WR: begin
                if (mem_ready)     state_d = ST_FETCH;
                else if (tmr_done) state_d = ST_FAULT;
            end
            ST_EXEC_R, ST_EXEC_I:            state_d = ST_ALU_WB;
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH,
            ST_JAL:                          state_d = ST_FETCH;
            ST_FAULT:                        state_d = ST_FAULT;
            default:                         state_d = ST_FAULT;
        endcase
    end

    // Any state change restarts the wait count, so each wait state starts from zero
    assign tmr_clear = (state_d != state_q);
    assign tmr_tick  = is_wait_state(state_q) && !mem_ready;

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .tick  (tmr_tick),
        .done  (tmr_done)
    );

    // State and sticky fault registers; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_FAULT) fault_q <= 1'b1;
        end
    end

    // Per-state datapath controls; everything quiet while reset is held
    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        old_pc_write = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_OP_ADD;
        result_src   = RES_ALU_OUT;
        adr_src      = ADR_PC;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read     = 1'b1;
                    alu_src_b    = SRC_B_FOUR;
                    result_src   = RES_ALU_RES;
                    ir_write     = mem_ready;
                    pc_write     = mem_ready;
                    old_pc_write = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    adr_src  = ADR_ALU_OUT;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM_DATA;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    adr_src   = ADR_ALU_OUT;
                end
                ST_EXEC_R: begin
                    alu_src_a = SRC_A_RS1;
                    alu_op    = ALU_OP_FUNCT;
                end
                ST_EXEC_I: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_OP_FUNCT;
                end
                ST_ALU_WB: reg_write = 1'b1;
                ST_BRANCH: begin
                    alu_src_a = SRC_A_RS1;
                    alu_op    = ALU_OP_SUB;
                    pc_write  = zero;
                end
                ST_JAL: begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_FOUR;
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule
